fetch_stage: RTL and testbench

Instruction-fetch stage of the IITB-RISC pipeline. Sits directly downstream of the PC-selection priority mux and holds the architectural PC register. Drives the instruction-memory request handshake, absorbs memory wait states and ID-stage stalls with a one-entry skid buffer, and loads the IF/ID pipeline register. Control-flow redirects squash wrong-path fetches.

---
 rtl/iitb_pkg.sv | 14 +
 rtl/fetch_skid.sv | 40 ++++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/iitb_pkg.sv
// Shared IITB-RISC definitions: datapath width, fetch FSM encoding and reset PC.
package iitb_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_FULL,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction that IF/ID could not take yet.
module fetch_skid #(
    parameter int WORD_W = iitb_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] load_instr,
    input  logic [WORD_W-1:0] load_pc,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc
);

    // NOTE: sequential state is always written with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the payload has no reset; valid qualifies it, and leaving data
    // registers unreset keeps them off the reset tree.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IITB-RISC instruction fetch: PC register, imem request handshake, skid buffer and IF/ID register.
module fetch_stage #(
    parameter int                WORD_W   = iitb_pkg::WORD_W,
    parameter logic [WORD_W-1:0] RESET_PC = iitb_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] new_pc,
    input  logic              redirect,
    output logic [WORD_W-1:0] pc_p1,
    input  logic              stall,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc,
    output logic [WORD_W-1:0] if_id_pc_p1
);

    import iitb_pkg::*;

    fetch_state_e      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] req_addr;
    logic              slot_free;

    logic              skid_load;
    logic              skid_pop;
    logic              skid_flush;
    logic              skid_valid;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_pc;

    assign pc_p1     = pc + WORD_W'(1);
    assign imem_addr = req_addr;
    assign slot_free = !if_id_valid || !stall;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_flush = 1'b0;
        case (state)
            ST_FETCH: skid_load  = !redirect && imem_ready && !slot_free;
            ST_FULL: begin
                skid_flush = redirect;
                skid_pop   = !redirect && slot_free;
            end
            default: ;
        endcase
    end

    fetch_skid #(
        .WORD_W(WORD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .pop       (skid_pop),
        .flush     (skid_flush),
        .load_instr(imem_rdata),
        .load_pc   (pc),
        .valid     (skid_valid),
        .instr     (skid_instr),
        .pc        (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            imem_req    <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_pc_p1 <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end

                ST_FETCH: begin
                    if (redirect) begin
                        pc          <= new_pc;
                        if_id_valid <= 1'b0;
                        // Without a response the stale address must stay on the bus.
                        if (imem_ready) begin
                            req_addr <= new_pc;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (imem_ready && slot_free) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= imem_rdata;
                        if_id_pc    <= pc;
                        if_id_pc_p1 <= pc_p1;
                        pc          <= new_pc;
                        req_addr    <= new_pc;
                    end else if (imem_ready) begin
                        pc       <= new_pc;
                        state    <= ST_FULL;
                        imem_req <= 1'b0;
                    end else if (slot_free) begin
                        if_id_valid <= 1'b0;
                    end
                end

                ST_FULL: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        pc          <= new_pc;
                        req_addr    <= new_pc;
                        state       <= ST_FETCH;
                        imem_req    <= 1'b1;
                    end else if (slot_free) begin
                        if_id_valid <= skid_valid;
                        if_id_instr <= skid_instr;
                        if_id_pc    <= skid_pc;
                        if_id_pc_p1 <= skid_pc + WORD_W'(1);
                        req_addr    <= pc;
                        state       <= ST_FETCH;
                        imem_req    <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (redirect) begin
                        pc <= new_pc;
                    end
                    if (redirect || slot_free) begin
                        if_id_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        req_addr <= redirect ? new_pc : pc;
                        state    <= ST_FETCH;
                    end
                end

                default: begin
                    state    <= ST_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, wait states, stall, redirect drain, flush over stall, wrap, async reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] new_pc;
    logic        redirect;
    logic [15:0] pc_p1;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_p1;
    logic [15:0] tgt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Zero-latency memory model and the PC priority mux stand-in.
    assign imem_rdata = imem_addr ^ 16'hA5A5;
    assign new_pc     = redirect ? tgt : pc_p1;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_pc     (new_pc),
        .redirect   (redirect),
        .pc_p1      (pc_p1),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc_p1(if_id_pc_p1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [15:0] i,
                              input logic [15:0] p);
        check({tag, "_valid"}, 16'(if_id_valid), 16'(v));
        check({tag, "_instr"}, if_id_instr, i);
        check({tag, "_pc"}, if_id_pc, p);
    endtask

    initial begin
        rst_n      = 1'b0;
        redirect   = 1'b0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        tgt        = 16'h0000;
        #2;
        check("rst_req", 16'(imem_req), 16'h0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_pc_p1", pc_p1, 16'h0001);
        check_ifid("rst", 1'b0, 16'h0000, 16'h0000);
        check("rst_ifid_pc_p1", if_id_pc_p1, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;

        // Stream: BOOT, then first fetch at 0, then one per cycle.
        tick();
        check("boot_req", 16'(imem_req), 16'h1);
        check("boot_addr", imem_addr, 16'h0000);
        check("boot_valid", 16'(if_id_valid), 16'h0);
        tick();
        check_ifid("s0", 1'b1, 16'hA5A5, 16'h0000);
        check("s0_pc_p1", if_id_pc_p1, 16'h0001);
        check("s0_addr", imem_addr, 16'h0001);
        tick();
        check_ifid("s1", 1'b1, 16'hA5A4, 16'h0001);
        check("s1_addr", imem_addr, 16'h0002);
        tick();
        check_ifid("s2", 1'b1, 16'hA5A7, 16'h0002);
        check("s2_addr", imem_addr, 16'h0003);
        tick();
        check_ifid("s3", 1'b1, 16'hA5A6, 16'h0003);
        tick();
        check_ifid("s4", 1'b1, 16'hA5A1, 16'h0004);
        check("s4_addr", imem_addr, 16'h0005);

        // Wait states at address 5.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_req", 16'(imem_req), 16'h1);
            check("ws_addr", imem_addr, 16'h0005);
            check("ws_valid", 16'(if_id_valid), 16'h0);
        end
        imem_ready = 1'b1;
        tick();
        check_ifid("ws5", 1'b1, 16'hA5A0, 16'h0005);
        check("ws5_addr", imem_addr, 16'h0006);
        tick();
        check_ifid("ws6", 1'b1, 16'hA5A3, 16'h0006);
        check("ws6_addr", imem_addr, 16'h0007);

        // Stall for 4 cycles: the fetch of 7 lands in the skid, IF/ID freezes.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_ifid("stall", 1'b1, 16'hA5A3, 16'h0006);
            check("stall_req", 16'(imem_req), 16'h0);
        end
        stall = 1'b0;
        tick();
        check_ifid("unstall7", 1'b1, 16'hA5A2, 16'h0007);
        check("unstall7_pc_p1", if_id_pc_p1, 16'h0008);
        check("unstall_req", 16'(imem_req), 16'h1);
        check("unstall_addr", imem_addr, 16'h0008);
        tick();
        check_ifid("unstall8", 1'b1, 16'hA5AD, 16'h0008);
        check("unstall8_addr", imem_addr, 16'h0009);

        // Redirect with same-cycle response: back to 7 on the next cycle.
        redirect = 1'b1;
        tgt      = 16'h0007;
        tick();
        check("redir7_addr", imem_addr, 16'h0007);
        check("redir7_valid", 16'(if_id_valid), 16'h0);

        // Redirect to 0x0040 while the fetch at 7 is waiting: drain 7 first.
        imem_ready = 1'b0;
        tgt        = 16'h0040;
        tick();
        redirect = 1'b0;
        check("drain_req", 16'(imem_req), 16'h1);
        check("drain_addr", imem_addr, 16'h0007);
        check("drain_valid", 16'(if_id_valid), 16'h0);
        tick();
        check("drain_hold_addr", imem_addr, 16'h0007);
        imem_ready = 1'b1;
        tick();
        check("drained_addr", imem_addr, 16'h0040);
        check("drained_valid", 16'(if_id_valid), 16'h0);
        tick();
        check_ifid("t40", 1'b1, 16'hA5E5, 16'h0040);
        check("t40_addr", imem_addr, 16'h0041);

        // Redirect beats stall while FULL.
        stall = 1'b1;
        tick();
        check("full_req", 16'(imem_req), 16'h0);
        redirect = 1'b1;
        tgt      = 16'h0100;
        tick();
        check("flush_valid", 16'(if_id_valid), 16'h0);
        check("flush_addr", imem_addr, 16'h0100);
        check("flush_req", 16'(imem_req), 16'h1);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        check_ifid("t100", 1'b1, 16'hA4A5, 16'h0100);

        // Wrap at 0xFFFF.
        redirect = 1'b1;
        tgt      = 16'hFFFF;
        tick();
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 16'hFFFF);
        check("wrap_pc_p1", pc_p1, 16'h0000);
        tick();
        check_ifid("wrap", 1'b1, 16'h5A5A, 16'hFFFF);
        check("wrap_ifid_pc_p1", if_id_pc_p1, 16'h0000);
        check("wrap_next_addr", imem_addr, 16'h0000);
        tick();
        check_ifid("w0", 1'b1, 16'hA5A5, 16'h0000);
        check("w0_pc_p1", if_id_pc_p1, 16'h0001);

        // Enter DRAIN at address 1, then assert reset asynchronously.
        imem_ready = 1'b0;
        redirect   = 1'b1;
        tgt        = 16'h0200;
        tick();
        redirect = 1'b0;
        check("pre_rst_req", 16'(imem_req), 16'h1);
        check("pre_rst_addr", imem_addr, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", 16'(imem_req), 16'h0);
        check("arst_addr", imem_addr, 16'h0000);
        check("arst_pc_p1", pc_p1, 16'h0001);
        check_ifid("arst", 1'b0, 16'h0000, 16'h0000);
        check("arst_ifid_pc_p1", if_id_pc_p1, 16'h0000);
        imem_ready = 1'b1;
        tick();
        check("in_rst_req", 16'(imem_req), 16'h0);
        rst_n = 1'b1;
        tick();
        check("reboot_req", 16'(imem_req), 16'h1);
        check("reboot_addr", imem_addr, 16'h0000);
        tick();
        check_ifid("reboot0", 1'b1, 16'hA5A5, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
